// File: rtl/ad_pkg.sv
// Shared definitions for the ADC sampling front end: sample width, the
// out-of-range clamp word and the transmit FSM state encoding.
package ad_pkg;

  // Sample width; matches the SPI transmitter data width.
  localparam int DATA_W = 12;

  // Word stored in place of the ADC output when the out-of-range flag is set.
  localparam logic [DATA_W-1:0] OTR_CLAMP = {DATA_W{1'b1}};

  // One-hot transmit handshake states.
  typedef enum logic [4:0] {
    TX_IDLE      = 5'b00001,
    TX_LOAD      = 5'b00010,
    TX_START     = 5'b00100,
    TX_WAIT_BUSY = 5'b01000,
    TX_WAIT_IDLE = 5'b10000
  } tx_state_e;

endpackage

// File: rtl/ad_sample_fifo.sv
// Small synchronous sample FIFO. A push and a pop in the same cycle both
// succeed, including when full (the slot being read is overwritten only at
// the clock edge) and when empty (the pushed word bypasses to the read port).
module ad_sample_fifo
  import ad_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LW-1:0]     o_level
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && (!o_empty || i_push);
  assign o_rd_data = o_empty ? i_wr_data : r_mem[r_rd_ptr];

  // Storage array written on every accepted push.
  // NOTE: the data array carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and fill level.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ad_sample_ctrl.sv
// ADC sample pacing and SPI transmitter feed. A free-running sample timer
// launches conversions, the captured word is queued in a small FIFO, and a
// transmit FSM hands each word to the SPI transmitter, retrying the start
// pulse if the transmitter never drops spi_nc.
module ad_sample_ctrl
  import ad_pkg::*;
#(
  parameter int DIV        = 50,
  parameter int CONV_CYC   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_TMO   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              ad_clk,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_otr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              spi_nc,
  output logic              overflow,
  output logic [15:0]       sample_cnt
);

  localparam int TIM_W  = $clog2(DIV);
  localparam int CONV_W = $clog2(CONV_CYC + 1);
  localparam int TMO_W  = $clog2(BUSY_TMO + 1);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

  logic [TIM_W-1:0]  r_timer;
  logic [CONV_W-1:0] r_conv_cnt;
  logic              r_ad_clk;
  logic              r_capture;
  logic              r_overflow;
  logic [15:0]       r_sample_cnt;
  logic [DATA_W-1:0] r_tx_data;
  logic [TMO_W-1:0]  r_tmo;
  tx_state_e         r_state;
  tx_state_e         w_state_nxt;

  logic              w_wrap;
  logic [DATA_W-1:0] w_sample;
  logic              w_pop;
  logic              w_push_ok;
  logic [DATA_W-1:0] w_fifo_rd_data;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [LVL_W-1:0]  w_unused_level;

  assign w_wrap     = en && (r_timer == TIM_W'(DIV - 1));
  assign w_sample   = ad_otr ? OTR_CLAMP : ad_data;
  assign w_pop      = (r_state == TX_LOAD);
  assign w_push_ok  = r_capture && (!w_fifo_full || w_pop);

  assign ad_clk     = r_ad_clk;
  assign tx_data    = r_tx_data;
  assign tx_start   = (r_state == TX_START);
  assign overflow   = r_overflow;
  assign sample_cnt = r_sample_cnt;

  // Sample timer: counts while enabled, clears and holds while disabled.
  always_ff @(posedge clk) begin
    if (rst || !en || w_wrap) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TIM_W'(1);
    end
  end

  // Conversion sequencer: strobe ad_clk, then flag the capture cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ad_clk   <= 1'b0;
      r_conv_cnt <= '0;
      r_capture  <= 1'b0;
    end else begin
      r_capture <= 1'b0;
      if (w_wrap) begin
        r_ad_clk   <= 1'b1;
        r_conv_cnt <= '0;
      end else if (r_ad_clk) begin
        if (r_conv_cnt == CONV_W'(CONV_CYC - 1)) begin
          r_ad_clk  <= 1'b0;
          r_capture <= 1'b1;
        end else begin
          r_conv_cnt <= r_conv_cnt + CONV_W'(1);
        end
      end
    end
  end

  // Sticky drop flag and accepted-sample counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      if (r_capture && w_fifo_full && !w_pop) r_overflow <= 1'b1;
      if (w_push_ok) r_sample_cnt <= r_sample_cnt + 16'd1;
    end
  end

  ad_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push_ok),
    .i_wr_data (w_sample),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_rd_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_level   (w_unused_level)
  );

  // Transmit FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= TX_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Transmit FSM next-state decode.
  // NOTE: defaulting the next state first keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TX_IDLE:      if (!w_fifo_empty && spi_nc) w_state_nxt = TX_LOAD;
      TX_LOAD:      w_state_nxt = TX_START;
      TX_START:     w_state_nxt = TX_WAIT_BUSY;
      TX_WAIT_BUSY: begin
        if (!spi_nc)                         w_state_nxt = TX_WAIT_IDLE;
        else if (r_tmo == TMO_W'(BUSY_TMO))  w_state_nxt = TX_START;
      end
      TX_WAIT_IDLE: if (spi_nc) w_state_nxt = TX_IDLE;
      default:      w_state_nxt = TX_IDLE;
    endcase
  end

  // Busy timeout: cycles spent in WAIT_BUSY with the transmitter still idle.
  always_ff @(posedge clk) begin
    if (rst || r_state != TX_WAIT_BUSY) begin
      r_tmo <= '0;
    end else if (spi_nc && r_tmo != TMO_W'(BUSY_TMO)) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  // Outgoing word: loaded only in LOAD, so it is stable through the frame.
  always_ff @(posedge clk) begin
    if (rst)          r_tx_data <= '0;
    else if (w_pop)   r_tx_data <= w_fifo_rd_data;
  end

endmodule

// File: tb/tb_ad_sample_ctrl.sv
// Directed bench for ad_sample_ctrl. dut_a runs the default pacing against
// a transmitter model; dut_b uses a short sample period against a transmitter
// that never answers, to exercise retries and FIFO overflow.
module tb_ad_sample_ctrl;
  import ad_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;

  logic              en_a, ad_clk_a, ad_otr_a, tx_start_a, spi_nc_a, overflow_a;
  logic [DATA_W-1:0] ad_data_a, tx_data_a;
  logic [15:0]       sample_cnt_a;

  logic              en_b, ad_clk_b, ad_otr_b, tx_start_b, spi_nc_b, overflow_b;
  logic [DATA_W-1:0] ad_data_b, tx_data_b;
  logic [15:0]       sample_cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  ad_sample_ctrl dut_a (
    .clk        (clk),
    .rst        (rst),
    .en         (en_a),
    .ad_clk     (ad_clk_a),
    .ad_data    (ad_data_a),
    .ad_otr     (ad_otr_a),
    .tx_data    (tx_data_a),
    .tx_start   (tx_start_a),
    .spi_nc     (spi_nc_a),
    .overflow   (overflow_a),
    .sample_cnt (sample_cnt_a)
  );

  ad_sample_ctrl #(.DIV(8)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .en         (en_b),
    .ad_clk     (ad_clk_b),
    .ad_data    (ad_data_b),
    .ad_otr     (ad_otr_b),
    .tx_data    (tx_data_b),
    .tx_start   (tx_start_b),
    .spi_nc     (spi_nc_b),
    .overflow   (overflow_b),
    .sample_cnt (sample_cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Transmitter model for dut_a: frame select low 2 cycles after the start
  // pulse, held low for 34 cycles.
  initial begin
    spi_nc_a = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start_a === 1'b1) begin
        repeat (2) @(negedge clk);
        spi_nc_a = 1'b0;
        repeat (34) @(negedge clk);
        spi_nc_a = 1'b1;
      end
    end
  end

  initial begin
    int n, hi, n_start, n_clk;
    int unsigned rise1;

    rst = 1'b1;
    en_a = 1'b0; ad_data_a = 12'hA5C; ad_otr_a = 1'b0;
    en_b = 1'b0; ad_data_b = 12'h3C7; ad_otr_b = 1'b0; spi_nc_b = 1'b1;
    repeat (3) tick();
    check("init_rst_outputs", {ad_clk_a, tx_start_a, overflow_a, tx_data_a, sample_cnt_a}, 0);
    rst = 1'b0;
    en_a = 1'b1;

    // Normal sampling and transmission.
    n = 0;
    while (!ad_clk_a && n < 60) begin tick(); n++; end
    check("t2_conv_seen", ad_clk_a, 1);
    rise1 = cyc;
    hi = 0;
    while (ad_clk_a && hi < 10) begin hi++; tick(); end
    check("t2_ad_clk_high_len", hi, 4);
    check("t2_no_push_in_capture", sample_cnt_a, 0);
    tick();
    check("t2_push", sample_cnt_a, 1);
    check("t2_no_start_at_push", tx_start_a, 0);
    tick();
    check("t2_no_start_in_load", tx_start_a, 0);
    tick();
    check("t2_start", tx_start_a, 1);
    check("t2_tx_data", tx_data_a, 12'hA5C);
    tick();
    check("t2_start_single", tx_start_a, 0);
    repeat (20) tick();
    check("t2_tx_data_hold", tx_data_a, 12'hA5C);
    check("t2_no_start_mid_frame", tx_start_a, 0);
    n = 0;
    while (!ad_clk_a && n < 60) begin tick(); n++; end
    check("t2_period", cyc - rise1, 50);

    // Out-of-range sample is clamped.
    ad_otr_a = 1'b1;
    ad_data_a = 12'h123;
    n = 0;
    while (!tx_start_a && n < 20) begin tick(); n++; end
    check("t3_start_seen", tx_start_a, 1);
    check("t3_otr_clamp", tx_data_a, 12'hFFF);
    check("t3_cnt", sample_cnt_a, 2);

    // Reset in the middle of a frame.
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("t1_rst_ad_clk", ad_clk_a, 0);
    check("t1_rst_tx_start", tx_start_a, 0);
    check("t1_rst_tx_data", tx_data_a, 0);
    check("t1_rst_overflow", overflow_a, 0);
    check("t1_rst_sample_cnt", sample_cnt_a, 0);
    repeat (2) tick();
    rst = 1'b0;
    ad_otr_a = 1'b0;
    ad_data_a = 12'hA5C;
    n = 0;
    n_start = 0;
    while (sample_cnt_a == 16'd0 && n < 80) begin
      if (tx_start_a) n_start++;
      tick();
      n++;
    end
    check("t1_push_after_rst", sample_cnt_a, 1);
    check("t1_no_early_start", n_start, 0);
    tick();
    tick();
    check("t1_start", tx_start_a, 1);
    check("t1_tx_data", tx_data_a, 12'hA5C);

    // Enable dropped during a conversion.
    n = 0;
    while (!ad_clk_a && n < 60) begin tick(); n++; end
    check("t5_conv_seen", ad_clk_a, 1);
    hi = 1;
    tick();
    en_a = 1'b0;
    while (ad_clk_a && hi < 10) begin hi++; tick(); end
    check("t5_ad_clk_high_len", hi, 4);
    tick();
    check("t5_push", sample_cnt_a, 2);
    n_clk = 0;
    n_start = 0;
    repeat (120) begin
      if (ad_clk_a)   n_clk++;
      if (tx_start_a) n_start++;
      tick();
    end
    check("t5_no_more_conv", n_clk, 0);
    check("t5_drained", n_start, 1);
    check("t5_cnt_hold", sample_cnt_a, 2);

    // Counter wrap from 16'hFFFF.
    force dut_a.r_sample_cnt = 16'hFFFF;
    tick();
    release dut_a.r_sample_cnt;
    check("t6_preload", sample_cnt_a, 16'hFFFF);
    en_a = 1'b1;
    n = 0;
    while (sample_cnt_a == 16'hFFFF && n < 80) begin tick(); n++; end
    check("t6_wrap", sample_cnt_a, 0);
    en_a = 1'b0;

    // Dead transmitter: retries and overflow. The first word sits in
    // tx_data, four more fill the FIFO, the sixth is dropped.
    en_b = 1'b1;
    n = 0;
    while (!tx_start_b && n < 30) begin tick(); n++; end
    check("t4_start_seen", tx_start_b, 1);
    check("t4_first_word", tx_data_b, 12'h3C7);
    ad_data_b = 12'h111;
    n = 0;
    while (sample_cnt_b != 16'd5 && n < 60) begin tick(); n++; end
    check("t4_cnt_full", sample_cnt_b, 5);
    check("t4_no_overflow_yet", overflow_b, 0);
    n = 0;
    while (!overflow_b && n < 20) begin tick(); n++; end
    check("t4_overflow", overflow_b, 1);
    check("t4_cnt_after_drop", sample_cnt_b, 5);
    repeat (2) begin
      n = 0;
      while (!tx_start_b && n < 20) begin tick(); n++; end
      tick();
      n = 1;
      while (!tx_start_b && n < 20) begin tick(); n++; end
      check("t4_retry_gap", n, 10);
      check("t4_retry_word", tx_data_b, 12'h3C7);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
